// File: rtl/max7219_rx_pkg.sv
// max7219_rx_pkg: shared MAX7219 register addresses, segment layout, Code-B font and scan states.
package max7219_rx_pkg;
  typedef enum logic [3:0] {
    A_NOOP      = 4'h0,
    A_DIGIT0    = 4'h1,
    A_DIGIT1    = 4'h2,
    A_DIGIT2    = 4'h3,
    A_DIGIT3    = 4'h4,
    A_DIGIT4    = 4'h5,
    A_DIGIT5    = 4'h6,
    A_DIGIT6    = 4'h7,
    A_DIGIT7    = 4'h8,
    A_DECODE    = 4'h9,
    A_INTENSITY = 4'hA,
    A_SCANLIM   = 4'hB,
    A_SHUTDOWN  = 4'hC,
    A_TEST      = 4'hF
  } reg_addr_t;
  typedef enum logic {SHUT, SCAN} scan_state_t;
  // segment byte layout is DP A B C D E F G from bit 7 down to bit 0
  localparam int SEG_DP = 7;
  function automatic logic [7:0] code_b(input logic [3:0] v, input logic dp);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h7E;
      4'h1: s = 8'h30;
      4'h2: s = 8'h6D;
      4'h3: s = 8'h79;
      4'h4: s = 8'h33;
      4'h5: s = 8'h5B;
      4'h6: s = 8'h5F;
      4'h7: s = 8'h70;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h7B;
      4'hA: s = 8'h01;
      4'hB: s = 8'h4F;
      4'hC: s = 8'h37;
      4'hD: s = 8'h0E;
      4'hE: s = 8'h67;
      default: s = 8'h00;
    endcase
    s[SEG_DP] = dp;
    return s;
  endfunction
endpackage

// File: rtl/max7219_rx_if.sv
// max7219_rx_if: serial link, decoded command and display signals of the MAX7219 emulator.
interface max7219_rx_if;
  logic        din;
  logic        sclk;
  logic        load;
  logic        cmd_valid;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        bit_err;
  logic [63:0] digit_regs;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown;
  logic        display_test;
  logic [7:0]  seg_out;
  logic [7:0]  dig_sel;
  modport master (
    output din, sclk, load,
    input  cmd_valid, cmd_addr, cmd_data, bit_err, digit_regs, decode_mode,
           intensity, scan_limit, shutdown, display_test, seg_out, dig_sel
  );
  modport slave (
    input  din, sclk, load,
    output cmd_valid, cmd_addr, cmd_data, bit_err, digit_regs, decode_mode,
           intensity, scan_limit, shutdown, display_test, seg_out, dig_sel
  );
endinterface

// File: rtl/max7219_rx_scan.sv
// max7219_rx_scan: digit multiplexer with scan limit, intensity PWM, Code-B font and display test.
module max7219_rx_scan #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_digits,
  input  logic [7:0]  i_decode,
  input  logic [3:0]  i_intensity,
  input  logic [2:0]  i_limit,
  input  logic        i_shutdown,
  input  logic        i_test,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_dig
);
  import max7219_rx_pkg::*;
  localparam int SUB = SCAN_DIV / 16;
  localparam int SW = SUB > 1 ? $clog2(SUB) : 1;
  scan_state_t r_state, w_next;
  logic [SW-1:0] r_tick, w_tick;
  logic [3:0] r_sub, w_sub;
  logic [2:0] r_d, w_d;
  logic [7:0] w_raw, w_src, w_seg, w_dig;
  logic w_end_tick, w_drive;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= SHUT;
      r_tick  <= '0;
      r_sub   <= '0;
      r_d     <= '0;
      o_seg   <= 8'h00;
      o_dig   <= 8'hFF;
    end else begin
      r_state <= w_next;
      r_tick  <= w_tick;
      r_sub   <= w_sub;
      r_d     <= w_d;
      o_seg   <= w_seg;
      o_dig   <= w_dig;
    end
  // a slot is 16 PWM sub-slots of SUB cycles; the digit advances after sub-slot 15
  always_comb begin
    w_next     = (i_shutdown && !i_test) ? SHUT : SCAN;
    w_end_tick = r_tick == SW'(SUB - 1);
    w_tick     = (r_state == SHUT || w_end_tick) ? '0 : r_tick + 1'b1;
    w_sub      = r_state == SHUT ? 4'd0 : r_sub + 4'(w_end_tick);
    w_d        = r_state == SHUT ? 3'd0 :
                 (w_end_tick && r_sub == 4'd15) ? (r_d >= i_limit ? 3'd0 : r_d + 3'd1) : r_d;
    w_raw      = i_digits[8*r_d +: 8];
    w_src      = i_test ? 8'hFF : i_decode[r_d] ? code_b(w_raw[3:0], w_raw[SEG_DP]) : w_raw;
    w_drive    = r_state == SCAN && (i_test || r_sub <= i_intensity);
    w_seg      = w_drive ? w_src : 8'h00;
    w_dig      = w_drive ? ~(8'd1 << r_d) : 8'hFF;
  end
endmodule

// File: rtl/max7219_rx.sv
// max7219_rx: MAX7219 serial receiver and register file driving a multiplexed 7-segment display.
module max7219_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int SCAN_DIV    = 1024
) (
  input logic          clk,
  input logic          reset,
  max7219_rx_if.slave  bus
);
  import max7219_rx_pkg::*;
  // SYNC_STAGES synchroniser flops, the edge-detect flop, then its previous value
  localparam int N = SYNC_STAGES + 2;
  logic [N-2:0] r_din;
  logic [N-1:0] r_sclk, r_load;
  // only frame[11:0] is ever used, so the shifter keeps the last 12 bits
  logic [11:0] r_sr;
  logic [4:0] r_cnt, w_cnt_base;
  logic w_din, w_sclk_rise, w_load_rise, w_load_fall, w_shift;
  logic [3:0] w_addr, r_addr;
  logic [7:0] w_data, r_data;
  logic r_valid, r_err;
  logic [7:0][7:0] r_dig;
  logic [7:0] r_decode;
  logic [3:0] r_int;
  logic [2:0] r_lim;
  logic r_shut, r_test;
  assign w_din       = r_din[N-2];
  assign w_sclk_rise = r_sclk[N-2] & ~r_sclk[N-1];
  assign w_load_rise = r_load[N-2] & ~r_load[N-1];
  assign w_load_fall = ~r_load[N-2] & r_load[N-1];
  assign w_shift     = w_sclk_rise & ~r_load[N-2];
  assign w_cnt_base  = w_load_fall ? 5'd0 : r_cnt;
  assign w_addr      = r_sr[11:8];
  assign w_data      = r_sr[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_din    <= '0;
      r_sclk   <= '0;
      r_load   <= '0;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_dig    <= '0;
      r_decode <= '0;
      r_int    <= '0;
      r_lim    <= '0;
      r_shut   <= 1'b1;
      r_test   <= 1'b0;
    end else begin
      r_din   <= {r_din[N-3:0], bus.din};
      r_sclk  <= {r_sclk[N-2:0], bus.sclk};
      r_load  <= {r_load[N-2:0], bus.load};
      if (w_shift) r_sr <= {r_sr[10:0], w_din};
      r_cnt   <= (w_shift && w_cnt_base != 5'd31) ? w_cnt_base + 5'd1 : w_cnt_base;
      r_valid <= w_load_rise;
      r_err   <= w_load_rise && r_cnt != 5'd16;
      if (w_load_rise) begin
        r_addr <= w_addr;
        r_data <= w_data;
        case (w_addr)
          A_DECODE:    r_decode <= w_data;
          A_INTENSITY: r_int    <= w_data[3:0];
          A_SCANLIM:   r_lim    <= w_data[2:0];
          A_SHUTDOWN:  r_shut   <= ~w_data[0];
          A_TEST:      r_test   <= w_data[0];
          default: if (w_addr >= A_DIGIT0 && w_addr <= A_DIGIT7) r_dig[w_addr[2:0] - 3'd1] <= w_data;
        endcase
      end
    end
  assign bus.cmd_valid    = r_valid;
  assign bus.cmd_addr     = r_addr;
  assign bus.cmd_data     = r_data;
  assign bus.bit_err      = r_err;
  assign bus.digit_regs   = r_dig;
  assign bus.decode_mode  = r_decode;
  assign bus.intensity    = r_int;
  assign bus.scan_limit   = r_lim;
  assign bus.shutdown     = r_shut;
  assign bus.display_test = r_test;
  max7219_rx_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk         (clk),
    .reset       (reset),
    .i_digits    (r_dig),
    .i_decode    (r_decode),
    .i_intensity (r_int),
    .i_limit     (r_lim),
    .i_shutdown  (r_shut),
    .i_test      (r_test),
    .o_seg       (bus.seg_out),
    .o_dig       (bus.dig_sel)
  );
endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: directed bench for the MAX7219 receiver with a 16-cycle scan slot.
module tb_max7219_rx;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int g_pulses, g_lat;
  logic g_err;
  max7219_rx_if bus ();
  max7219_rx #(.SYNC_STAGES(2), .SCAN_DIV(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic shift_bits(input logic [31:0] v, input int n);
    @(negedge clk);
    bus.load = 1'b0;
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      bus.din  = v[i];
      bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic commit();
    g_pulses = 0;
    g_lat    = -1;
    g_err    = 1'b0;
    bus.load = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) begin
        if (g_lat < 0) g_lat = c;
        g_pulses++;
        g_err = g_err | bus.bit_err;
      end
    end
  endtask
  task automatic frame(input logic [31:0] v, input int n);
    shift_bits(v, n);
    commit();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.din = 1'b0;
    bus.sclk = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.dig_sel !== 8'hFF) begin failures++; $display("FAIL reset_dig_sel got=%h exp=ff", bus.dig_sel); end
    checks++; if (bus.seg_out !== 8'h00) begin failures++; $display("FAIL reset_seg_out got=%h exp=00", bus.seg_out); end
    checks++; if (bus.digit_regs !== 64'h0) begin failures++; $display("FAIL reset_digits got=%h exp=0", bus.digit_regs); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.bit_err, bus.cmd_addr, bus.cmd_data} !== 14'h0) begin
      failures++; $display("FAIL reset_cmd got=%h exp=0", {bus.cmd_valid, bus.bit_err, bus.cmd_addr, bus.cmd_data});
    end
    checks++;
    if ({bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test} !== 17'h00002) begin
      failures++; $display("FAIL reset_regs got=%h exp=00002", {bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test});
    end
  endtask
  task automatic test_shutdown_frame();
    frame(32'h0C01, 16);
    checks++; if (g_pulses != 1) begin failures++; $display("FAIL cfg_pulses got=%0d exp=1", g_pulses); end
    checks++; if (g_lat != 3) begin failures++; $display("FAIL cfg_latency got=%0d exp=3", g_lat); end
    checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL cfg_bit_err got=%b exp=0", g_err); end
    checks++; if ({bus.cmd_addr, bus.cmd_data} !== 12'hC01) begin failures++; $display("FAIL cfg_cmd got=%h exp=c01", {bus.cmd_addr, bus.cmd_data}); end
    checks++; if (bus.shutdown !== 1'b0) begin failures++; $display("FAIL cfg_shutdown got=%b exp=0", bus.shutdown); end
  endtask
  task automatic test_digit_noop();
    frame(32'h0312, 16);
    checks++; if (bus.digit_regs !== 64'h0000_0000_0012_0000) begin failures++; $display("FAIL digit2 got=%h exp=0000000000120000", bus.digit_regs); end
    checks++; if ({bus.cmd_addr, bus.cmd_data} !== 12'h312) begin failures++; $display("FAIL digit2_cmd got=%h exp=312", {bus.cmd_addr, bus.cmd_data}); end
    frame(32'h0000, 16);
    checks++; if (g_pulses != 1) begin failures++; $display("FAIL noop_pulses got=%0d exp=1", g_pulses); end
    checks++; if ({bus.cmd_addr, bus.cmd_data} !== 12'h000) begin failures++; $display("FAIL noop_cmd got=%h exp=000", {bus.cmd_addr, bus.cmd_data}); end
    checks++; if (bus.digit_regs !== 64'h0000_0000_0012_0000) begin failures++; $display("FAIL noop_digits got=%h exp=0000000000120000", bus.digit_regs); end
    checks++;
    if ({bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test} !== 17'h00000) begin
      failures++; $display("FAIL noop_regs got=%h exp=00000", {bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test});
    end
  endtask
  task automatic test_bit_count();
    frame(32'h0001_0A05, 17);
    checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL long_bit_err got=%b exp=1", g_err); end
    checks++; if (bus.intensity !== 4'h5) begin failures++; $display("FAIL long_intensity got=%h exp=5", bus.intensity); end
    frame(32'h0A03, 15);
    checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL short_bit_err got=%b exp=1", g_err); end
    checks++; if ({bus.cmd_addr, bus.cmd_data} !== 12'hA03) begin failures++; $display("FAIL short_cmd got=%h exp=a03", {bus.cmd_addr, bus.cmd_data}); end
    checks++; if (bus.intensity !== 4'h3) begin failures++; $display("FAIL short_intensity got=%h exp=3", bus.intensity); end
  endtask
  task automatic test_scan();
    int n = 0;
    int errs = 0;
    logic [7:0] exp_dig, exp_seg;
    frame(32'h0A0F, 16);
    frame(32'h0B02, 16);
    while (bus.dig_sel !== 8'hFB && n < 200) begin @(negedge clk); n++; end
    while (bus.dig_sel === 8'hFB && n < 300) begin @(negedge clk); n++; end
    checks++; if (n >= 300) begin failures++; $display("FAIL scan_sync got=%0d exp=<300 cycles", n); end
    for (int k = 0; k < 64; k++) begin
      exp_dig = k < 16 ? 8'hFE : k < 32 ? 8'hFD : k < 48 ? 8'hFB : 8'hFE;
      exp_seg = (k >= 32 && k < 48) ? 8'h12 : 8'h00;
      if (bus.dig_sel !== exp_dig || bus.seg_out !== exp_seg) errs++;
      @(negedge clk);
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL scan_sequence got=%0d bad cycles exp=0", errs); end
  endtask
  task automatic test_pwm();
    int on = 0;
    int off = 0;
    frame(32'h09FF, 16);
    frame(32'h0105, 16);
    frame(32'h0A00, 16);
    frame(32'h0B00, 16);
    repeat (32) @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      if (bus.dig_sel === 8'hFE && bus.seg_out === 8'h5B) on++;
      if (bus.dig_sel === 8'hFF && bus.seg_out === 8'h00) off++;
      @(negedge clk);
    end
    checks++; if (on != 4) begin failures++; $display("FAIL pwm_on got=%0d exp=4", on); end
    checks++; if (off != 60) begin failures++; $display("FAIL pwm_off got=%0d exp=60", off); end
  endtask
  task automatic test_display_test();
    int good = 0;
    frame(32'h0C00, 16);
    checks++; if (bus.shutdown !== 1'b1) begin failures++; $display("FAIL shut_flag got=%b exp=1", bus.shutdown); end
    for (int k = 0; k < 32; k++) begin
      if (bus.dig_sel === 8'hFF && bus.seg_out === 8'h00) good++;
      @(negedge clk);
    end
    checks++; if (good != 32) begin failures++; $display("FAIL shut_blank got=%0d exp=32", good); end
    frame(32'h0F01, 16);
    checks++; if (bus.display_test !== 1'b1) begin failures++; $display("FAIL test_flag got=%b exp=1", bus.display_test); end
    good = 0;
    for (int k = 0; k < 32; k++) begin
      if (bus.dig_sel === 8'hFE && bus.seg_out === 8'hFF) good++;
      @(negedge clk);
    end
    checks++; if (good != 32) begin failures++; $display("FAIL test_full got=%0d exp=32", good); end
  endtask
  task automatic test_reset_midframe();
    shift_bits(32'hA5, 8);
    reset = 1'b1;
    bus.sclk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    frame(32'h0277, 16);
    checks++; if (g_pulses != 1 || g_err !== 1'b0) begin failures++; $display("FAIL mid_frame got=pulses %0d err %b exp=pulses 1 err 0", g_pulses, g_err); end
    checks++; if (bus.digit_regs !== 64'h0000_0000_0000_7700) begin failures++; $display("FAIL mid_digits got=%h exp=0000000000007700", bus.digit_regs); end
    checks++;
    if ({bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test} !== 17'h00002) begin
      failures++; $display("FAIL mid_regs got=%h exp=00002", {bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown, bus.display_test});
    end
    checks++; if (bus.dig_sel !== 8'hFF) begin failures++; $display("FAIL mid_dig_sel got=%h exp=ff", bus.dig_sel); end
  endtask
  initial begin
    test_reset();
    test_shutdown_frame();
    test_digit_noop();
    test_bit_count();
    test_scan();
    test_pwm();
    test_display_test();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
